// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch-stage
// RUN/HALT state encoding, plus a saturating counter helper.
package cpu_pkg;

    localparam int PC_W    = 19;
    localparam int INSTR_W = 19;

    localparam logic [INSTR_W-1:0] NOP = 19'h00000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } if_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its redirect / hold / increment selection.
// The increment wraps silently at the top of the address space.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_redirect,
    input  logic [W-1:0] i_redirect_pc,
    input  logic         i_hold,
    input  logic         i_advance,
    output logic [W-1:0] o_pc
);

    logic [W-1:0] r_pc;
    logic [W-1:0] w_pc_next;

    // A redirect beats a halt freeze: the target belongs to an older instruction.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = i_redirect_pc;
        end else if (i_hold) begin
            w_pc_next = r_pc;
        end else if (i_advance) begin
            w_pc_next = r_pc + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register, RUN/HALT control and a
// saturating count of load-use stall cycles.
module if_stage #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCwrite,
    input  logic               IF_IDwrite,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [PC_W-1:0]    ID_pc,
    output logic               ID_valid,
    output logic               halted,
    output logic [15:0]        stall_count
);
    import cpu_pkg::*;

    localparam logic [INSTR_W-1:0] ID_NOP = INSTR_W'(NOP);

    if_state_e          r_state;
    logic               r_halted;
    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;
    logic [15:0]        r_stall_count;

    logic [PC_W-1:0]    w_pc;
    logic               w_freeze;
    logic               w_stall_cycle;

    // Fetch stops both in HALT and on the very cycle decode reports the HALT.
    assign w_freeze      = (r_state == ST_HALT) || halt;
    assign w_stall_cycle = (r_state == ST_RUN) && !PCwrite && !redirect && !halt;

    pc_reg #(
        .W (PC_W)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_hold        (w_freeze),
        .i_advance     (PCwrite),
        .o_pc          (w_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt && !redirect) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // A redirect squashes ID even when hazard logic asked for a hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_instr <= ID_NOP;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else if (redirect || w_freeze) begin
            r_id_instr <= ID_NOP;
            r_id_valid <= 1'b0;
        end else if (IF_IDwrite) begin
            r_id_instr <= imem_data;
            r_id_pc    <= w_pc;
            r_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall_cycle) begin
            r_stall_count <= sat_inc16(r_stall_count);
        end
    end

    assign imem_addr   = w_pc;
    assign ID_instr    = r_id_instr;
    assign ID_pc       = r_id_pc;
    assign ID_valid    = r_id_valid;
    assign halted      = r_halted;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a cycle-level reference model and literal
// expectations at each scenario boundary.
module tb_if_stage;

    localparam int PW = 19;
    localparam int IW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          PCwrite;
    logic          IF_IDwrite;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          halt;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] ID_instr;
    logic [PW-1:0] ID_pc;
    logic          ID_valid;
    logic          halted;
    logic [15:0]   stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] imem_f(input logic [PW-1:0] a);
        return (a * 19'd37) ^ 19'h2A5A5;
    endfunction

    assign imem_data = imem_f(imem_addr);

    if_stage #(.PC_W(PW), .INSTR_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCwrite     (PCwrite),
        .IF_IDwrite  (IF_IDwrite),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .ID_instr    (ID_instr),
        .ID_pc       (ID_pc),
        .ID_valid    (ID_valid),
        .halted      (halted),
        .stall_count (stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next state computed from the priority rules per edge.
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_id_pc;
    logic [IW-1:0] m_id_instr;
    logic          m_id_valid;
    logic          m_halted;
    int            m_stall;
    bit            m_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_en       <= 1'b1;
            m_pc       <= '0;
            m_id_pc    <= '0;
            m_id_instr <= '0;
            m_id_valid <= 1'b0;
            m_halted   <= 1'b0;
            m_stall    <= 0;
        end else begin
            if (redirect)
                m_pc <= redirect_pc;
            else if (!(m_halted || halt) && PCwrite)
                m_pc <= PW'((int'(m_pc) + 1) % (1 << PW));

            if (redirect || m_halted || halt) begin
                m_id_instr <= '0;
                m_id_valid <= 1'b0;
            end else if (IF_IDwrite) begin
                m_id_instr <= imem_f(m_pc);
                m_id_pc    <= m_pc;
                m_id_valid <= 1'b1;
            end

            if (!m_halted && halt && !redirect)
                m_halted <= 1'b1;

            if (!m_halted && !PCwrite && !redirect && !halt)
                m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("cyc_imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("cyc_id_instr", 32'(ID_instr), 32'(m_id_instr));
            chk("cyc_id_pc", 32'(ID_pc), 32'(m_id_pc));
            chk("cyc_id_valid", 32'(ID_valid), 32'(m_id_valid));
            chk("cyc_halted", 32'(halted), 32'(m_halted));
            chk("cyc_stall_count", 32'(stall_count), 32'(m_stall));
        end
    end

    task automatic drive(input logic r, input logic pw, input logic iw,
                         input logic rd, input logic [PW-1:0] rpc, input logic h);
        rst         = r;
        PCwrite     = pw;
        IF_IDwrite  = iw;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, '0, 0);
        tick();
        tick();
        chk("rst_pc", 32'(imem_addr), 32'h0);
        chk("rst_id_valid", 32'(ID_valid), 32'h0);
        chk("rst_id_instr", 32'(ID_instr), 32'h0);
        chk("rst_id_pc", 32'(ID_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_stall", 32'(stall_count), 32'h0);

        // Free run: ID_pc walks 0,1,2,3
        drive(0, 1, 1, 0, '0, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("run_id_pc", 32'(ID_pc), 32'(k));
            chk("run_id_valid", 32'(ID_valid), 32'h1);
            if (k == 0) chk("run_instr0", 32'(ID_instr), 32'h2A5A5);
        end
        tick();
        chk("run_pc5", 32'(imem_addr), 32'h5);

        // Two-cycle load-use stall at PC=5
        drive(0, 0, 0, 0, '0, 0);
        tick();
        tick();
        chk("stall_pc", 32'(imem_addr), 32'h5);
        chk("stall_id_pc", 32'(ID_pc), 32'h4);
        chk("stall_id_instr", 32'(ID_instr), 32'(imem_f(19'h4)));
        chk("stall_count2", 32'(stall_count), 32'h2);

        drive(0, 1, 1, 0, '0, 0);
        repeat (3) tick();
        chk("pc8", 32'(imem_addr), 32'h8);

        // Redirect overrides a simultaneous stall
        drive(0, 0, 0, 1, 19'h00040, 0);
        tick();
        chk("redir_pc", 32'(imem_addr), 32'h40);
        chk("redir_valid", 32'(ID_valid), 32'h0);
        chk("redir_id_pc_held", 32'(ID_pc), 32'h7);
        chk("redir_no_stall", 32'(stall_count), 32'h2);
        drive(0, 1, 1, 0, '0, 0);
        tick();
        chk("redir_id_pc", 32'(ID_pc), 32'h40);
        chk("redir_valid2", 32'(ID_valid), 32'h1);

        // PC advances, IF/ID holds
        drive(0, 1, 0, 0, '0, 0);
        tick();
        chk("skip_pc", 32'(imem_addr), 32'h42);
        chk("skip_id_pc", 32'(ID_pc), 32'h40);

        // PC holds, IF/ID reloads from same PC
        drive(0, 0, 1, 0, '0, 0);
        tick();
        chk("reload_pc", 32'(imem_addr), 32'h42);
        chk("reload_id_pc", 32'(ID_pc), 32'h42);
        chk("reload_stall", 32'(stall_count), 32'h3);

        // Wrap at top of address space
        drive(0, 1, 1, 1, 19'h7FFFF, 0);
        tick();
        chk("wrap_pre_pc", 32'(imem_addr), 32'h7FFFF);
        drive(0, 1, 1, 0, '0, 0);
        tick();
        chk("wrap_pc", 32'(imem_addr), 32'h0);
        chk("wrap_id_pc", 32'(ID_pc), 32'h7FFFF);

        // halt together with redirect: redirect wins, no HALT
        drive(0, 1, 1, 1, 19'd12, 1);
        tick();
        chk("haltredir_halted", 32'(halted), 32'h0);
        chk("haltredir_pc", 32'(imem_addr), 32'd12);

        // HALT at PC=12
        drive(0, 1, 1, 0, '0, 1);
        tick();
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_pc", 32'(imem_addr), 32'd12);
        chk("halt_valid", 32'(ID_valid), 32'h0);
        drive(0, 0, 1, 0, '0, 0);
        repeat (3) tick();
        chk("halt_pc_frozen", 32'(imem_addr), 32'd12);
        chk("halt_valid_off", 32'(ID_valid), 32'h0);
        chk("halt_sticky", 32'(halted), 32'h1);
        chk("halt_no_stall", 32'(stall_count), 32'h3);

        drive(1, 0, 0, 0, '0, 0);
        tick();
        chk("halt_rst_pc", 32'(imem_addr), 32'h0);
        chk("halt_rst_halted", 32'(halted), 32'h0);
        chk("halt_rst_stall", 32'(stall_count), 32'h0);

        // First edge after reset loads address 0
        drive(0, 1, 1, 0, '0, 0);
        tick();
        chk("post_rst_id_pc", 32'(ID_pc), 32'h0);
        chk("post_rst_valid", 32'(ID_valid), 32'h1);
        chk("post_rst_instr", 32'(ID_instr), 32'h2A5A5);

        // Long stall saturates the counter
        drive(0, 0, 1, 0, '0, 0);
        repeat (70000) tick();
        chk("stall_saturate", 32'(stall_count), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
